// File: rtl/scan_seq_pkg.sv
// Shared constants and FSM encoding for the scan address sequencer.
package scan_seq_pkg;
    localparam int N_CH   = 16;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/scan_addr_sequencer_if.sv
// Control/config inputs and decoder-facing outputs of the scan sequencer.
interface scan_addr_sequencer_if #(
    parameter int DWELL_W = 8
);
    import scan_seq_pkg::*;

    logic               start;
    logic               stop;
    logic [N_CH-1:0]    mask;
    logic [DWELL_W-1:0] dwell;
    logic               cont;
    logic               en;
    logic [ADDR_W-1:0]  a;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, stop, mask, dwell, cont,
        input  en, a, busy, done, err
    );

    modport slave (
        input  start, stop, mask, dwell, cont,
        output en, a, busy, done, err
    );
endinterface

// File: rtl/scan_addr_sequencer_mask_next_finder.sv
// Combinational search of a channel mask: next set bit above an index and lowest set bit.
module mask_next_finder
    import scan_seq_pkg::*;
(
    input  logic [N_CH-1:0]   mask_i,
    input  logic [ADDR_W-1:0] cur_i,
    output logic [ADDR_W-1:0] next_o,
    output logic              found_above_o,
    output logic [ADDR_W-1:0] lowest_o,
    output logic              any_set_o
);
    always_comb begin
        next_o        = '0;
        found_above_o = 1'b0;
        lowest_o      = '0;
        any_set_o     = |mask_i;
        // Walk downward so the last hit written is the lowest qualifying bit.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                lowest_o = ADDR_W'(i);
                if (i > int'(cur_i)) begin
                    next_o        = ADDR_W'(i);
                    found_above_o = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/scan_addr_sequencer.sv
// Steps decoder enable/address through the masked channels, holding each for a latched dwell.
module scan_addr_sequencer
    import scan_seq_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    scan_addr_sequencer_if.slave  bus
);
    state_e             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] last_q, last_d;
    logic [N_CH-1:0]    mask_q, mask_d;
    logic               cont_q, cont_d;
    logic               stop_q, stop_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  a_q, a_d;

    logic [N_CH-1:0]    find_mask;
    logic [ADDR_W-1:0]  next_idx;
    logic [ADDR_W-1:0]  low_idx;
    logic               found_above;
    logic               any_set;
    logic               stop_now;

    // While idle the finder looks at the live mask so the first channel is ready on the start edge.
    assign find_mask = (state_q == ST_IDLE) ? bus.mask : mask_q;

    mask_next_finder u_finder (
        .mask_i        (find_mask),
        .cur_i         (a_q),
        .next_o        (next_idx),
        .found_above_o (found_above),
        .lowest_o      (low_idx),
        .any_set_o     (any_set)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        mask_d   = mask_q;
        cont_d   = cont_q;
        stop_d   = stop_q;
        a_d      = a_q;
        err_d    = 1'b0;
        stop_now = stop_q | bus.stop;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mask_d = bus.mask;
                    last_d = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
                    cont_d = bus.cont;
                    cnt_d  = '0;
                    stop_d = 1'b0;
                    if (any_set) begin
                        state_d = ST_SCAN;
                        a_d     = low_idx;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                stop_d = stop_now;
                if (cnt_q == last_q) begin
                    cnt_d = '0;
                    if (stop_now) begin
                        state_d = ST_DONE;
                    end else if (found_above) begin
                        a_d = next_idx;
                    end else if (cont_q) begin
                        a_d = low_idx;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                stop_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        en_d   = (state_d == ST_SCAN);
        busy_d = (state_d == ST_SCAN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            a_q     <= a_d;
        end
    end

    // Latched scan configuration is only meaningful after a start, so it carries no reset.
    always_ff @(posedge clk) begin
        last_q <= last_d;
        mask_q <= mask_d;
        cont_q <= cont_d;
    end

    assign bus.en   = en_q;
    assign bus.a    = a_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_scan_addr_sequencer.sv
// Bench for scan_addr_sequencer: vector table, directed corner sequences and a randomized model check.
module tb_scan_addr_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scan_addr_sequencer_if #(.DWELL_W(8)) bus ();
    scan_addr_sequencer #(.DWELL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [3:0] last_a;

    typedef struct {
        logic [15:0] mask;
        logic [7:0]  dwell;
        int          n_en;
        logic [3:0]  a_first;
        logic [3:0]  a_last;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Observation word: {en, busy, done, err, a}
    function automatic logic [7:0] obs();
        return {bus.en, bus.busy, bus.done, bus.err, bus.a};
    endfunction

    task automatic run_vec(input vec_t v);
        int n = 0;
        int guard = 0;
        logic [3:0] first_a = 4'd0;
        logic [3:0] lst_a = 4'd0;
        @(negedge clk);
        bus.start = 1'b1; bus.stop = 1'b0;
        bus.mask = v.mask; bus.dwell = v.dwell; bus.cont = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.en && guard < 300) begin
            if (n == 0) first_a = bus.a;
            lst_a = bus.a;
            n++;
            bus.mask  = 16'hFFFF;
            bus.start = (n == 2);
            @(negedge clk);
            bus.start = 1'b0;
            guard++;
        end
        chk("vec_end", {bus.busy, bus.done, bus.err, 5'd0}, {1'b0, 1'b1, v.err, 5'd0});
        chk("vec_n_en", 8'(n), 8'(v.n_en));
        if (v.n_en > 0) begin
            chk("vec_a_first", {4'd0, first_a}, {4'd0, v.a_first});
            chk("vec_a_last", {4'd0, lst_a}, {4'd0, v.a_last});
            last_a = v.a_last;
        end
        @(negedge clk);
        chk("vec_idle", obs(), {4'b0000, last_a});
    endtask

    // Reference: the visited channel list repeated eff times each; a stop seen during
    // en-cycle s ends the scan at the end of the channel that contains s.
    task automatic run_scan(input logic [15:0] m, input logic [7:0] dw, input bit c, input int stop_at);
        int chans[$];
        int eff, nch, len, sl, ea;
        for (int i = 0; i < 16; i++) if (m[i]) chans.push_back(i);
        nch = chans.size();
        eff = (dw == 8'd0) ? 1 : int'(dw);
        @(negedge clk);
        bus.start = 1'b1; bus.mask = m; bus.dwell = dw; bus.cont = c;
        bus.stop = 1'($urandom_range(0, 1));
        if (nch == 0) begin
            @(negedge clk);
            bus.start = 1'b0; bus.stop = 1'b0;
            chk("zero_done", obs(), {4'b0011, last_a});
            @(negedge clk);
            chk("zero_idle", obs(), {4'b0000, last_a});
            return;
        end
        len = c ? 1000 : nch * eff;
        if (stop_at >= 0) begin
            sl = ((stop_at / eff) + 1) * eff;
            if (sl < len) len = sl;
        end
        for (int p = 0; p < len; p++) begin
            @(negedge clk);
            ea = chans[(p / eff) % nch];
            chk("scan", obs(), {4'b1100, 4'(ea)});
            last_a = 4'(ea);
            bus.start = ($urandom_range(0, 7) == 0);
            bus.mask  = 16'($urandom);
            bus.dwell = 8'($urandom);
            bus.cont  = 1'($urandom);
            bus.stop  = (p == stop_at);
        end
        @(negedge clk);
        chk("done", obs(), {4'b0010, last_a});
        bus.start = 1'($urandom_range(0, 1));
        bus.stop  = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle", obs(), {4'b0000, last_a});
        bus.start = 1'b0;
        bus.stop  = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rm;
        logic [7:0]  rd;
        bit          rc;
        int          rs, tot;

        vecs.push_back('{16'h0005, 8'd3, 6, 4'd0, 4'd2, 1'b0});
        vecs.push_back('{16'h8001, 8'd0, 2, 4'd0, 4'd15, 1'b0});
        vecs.push_back('{16'h0000, 8'd5, 0, 4'd0, 4'd0, 1'b1});
        vecs.push_back('{16'hFFFF, 8'd1, 16, 4'd0, 4'd15, 1'b0});
        vecs.push_back('{16'h0100, 8'd4, 4, 4'd8, 4'd8, 1'b0});
        vecs.push_back('{16'hF000, 8'd2, 8, 4'd12, 4'd15, 1'b0});
        vecs.push_back('{16'h0003, 8'd2, 4, 4'd0, 4'd1, 1'b0});

        bus.start = 1'b0; bus.stop = 1'b0; bus.mask = '0; bus.dwell = '0; bus.cont = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset", obs(), 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_idle", obs(), 8'h00);
        last_a = 4'd0;

        foreach (vecs[i]) run_vec(vecs[i]);

        run_scan(16'h0005, 8'd3, 1'b0, -1);
        run_scan(16'h8001, 8'd0, 1'b0, -1);
        run_scan(16'h0110, 8'd2, 1'b1, 1);
        run_scan(16'h0110, 8'd2, 1'b1, 5);
        run_scan(16'h0040, 8'd3, 1'b1, 7);
        run_scan(16'h0000, 8'd2, 1'b1, -1);
        run_scan(16'h0A50, 8'd3, 1'b0, 4);

        // Reset in the first cycle of channel 5: everything clears and no done follows.
        @(negedge clk);
        bus.start = 1'b1; bus.stop = 1'b0; bus.mask = 16'h00F0; bus.dwell = 8'd3; bus.cont = 1'b0;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk("rst_pre", obs(), {4'b1100, (p < 3) ? 4'd4 : 4'd5});
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", obs(), 8'h00);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", obs(), 8'h00);
        end
        last_a = 4'd0;
        run_scan(16'h00F0, 8'd1, 1'b0, -1);

        for (int k = 0; k < 40; k++) begin
            rm = 16'($urandom);
            if (k % 3 == 0) rm = rm & 16'($urandom) & 16'($urandom);
            if (k % 13 == 5) rm = 16'h0000;
            rd = 8'($urandom_range(0, 3));
            rc = 1'($urandom);
            tot = 0;
            for (int i = 0; i < 16; i++) if (rm[i]) tot++;
            tot = tot * ((rd == 8'd0) ? 1 : int'(rd));
            if (rc) rs = $urandom_range(0, 2 * tot + 1);
            else    rs = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, tot + 1);
            run_scan(rm, rd, rc, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
